// File: rtl/des_axil_pkg.sv
// Shared register map, response codes and STATUS bit positions for the DES
// AXI4-Lite register front end.
package des_axil_pkg;

  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_STATUS  = 5'h04;
  localparam logic [4:0] REG_KEY_LO  = 5'h08;
  localparam logic [4:0] REG_KEY_HI  = 5'h0C;
  localparam logic [4:0] REG_DATA_LO = 5'h10;
  localparam logic [4:0] REG_DATA_HI = 5'h14;
  localparam logic [4:0] REG_RES_LO  = 5'h18;
  localparam logic [4:0] REG_RES_HI  = 5'h1C;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

endpackage

// File: rtl/des_axil_slave_regs_if.sv
// AXI4-Lite bus bundle between the VIP master and the DES register slave.
interface des_axil_slave_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/des_axil_wstrb_reg.sv
// One 32-bit software register; each byte lane updates only when its strobe is set.
module des_axil_wstrb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/des_axil_slave_regs.sv
// AXI4-Lite register front end for the DES core: key/data/result bank,
// start pulse generation and sticky done tracking.
module des_axil_slave_regs
  import des_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  des_axil_slave_regs_if.slave  s_axi,
  output logic                  core_start,
  output logic [63:0]           core_key,
  output logic [63:0]           core_data,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic [63:0]           core_result
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Anything above the 32-byte window is an error; byte offset within a word is ignored.
  function automatic logic in_range(input logic [AW-1:2] word_addr);
    return (word_addr >> 3) == '0;
  endfunction

  function automatic logic [4:0] reg_off(input logic [AW-1:2] word_addr);
    return {word_addr[4:2], 2'b00};
  endfunction

  logic          awready_q, wready_q, bvalid_q;
  resp_t         bresp_q;
  logic          aw_held, w_held;
  logic [AW-1:2] awaddr_q;
  logic [31:0]   wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          commit, wr_ok, b_hs;
  logic [4:0]    wr_off;

  assign commit = aw_held & w_held;
  assign wr_ok  = in_range(awaddr_q);
  assign wr_off = reg_off(awaddr_q);
  assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;

  // Write channel: AW and W captured independently, committed together, one outstanding.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (s_axi.S_AXI_AWVALID && awready_q) begin
        aw_held   <= 1'b1;
        awaddr_q  <= s_axi.S_AXI_AWADDR[AW-1:2];
        awready_q <= 1'b0;
      end else if (b_hs || (!aw_held && !bvalid_q)) begin
        awready_q <= 1'b1;
      end

      if (s_axi.S_AXI_WVALID && wready_q) begin
        w_held   <= 1'b1;
        wdata_q  <= s_axi.S_AXI_WDATA;
        wstrb_q  <= s_axi.S_AXI_WSTRB;
        wready_q <= 1'b0;
      end else if (b_hs || (!w_held && !bvalid_q)) begin
        wready_q <= 1'b1;
      end

      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;

  logic [31:0] key_lo, key_hi, data_lo, data_hi;
  logic [31:0] res_lo, res_hi;
  logic        done_q;
  logic        wr_hit;

  assign wr_hit = commit & wr_ok;

  des_axil_wstrb_reg u_key_lo (
    .clk(ACLK), .rst(ARESET), .we(wr_hit && (wr_off == REG_KEY_LO)),
    .wstrb(wstrb_q), .wdata(wdata_q), .q(key_lo)
  );
  des_axil_wstrb_reg u_key_hi (
    .clk(ACLK), .rst(ARESET), .we(wr_hit && (wr_off == REG_KEY_HI)),
    .wstrb(wstrb_q), .wdata(wdata_q), .q(key_hi)
  );
  des_axil_wstrb_reg u_data_lo (
    .clk(ACLK), .rst(ARESET), .we(wr_hit && (wr_off == REG_DATA_LO)),
    .wstrb(wstrb_q), .wdata(wdata_q), .q(data_lo)
  );
  des_axil_wstrb_reg u_data_hi (
    .clk(ACLK), .rst(ARESET), .we(wr_hit && (wr_off == REG_DATA_HI)),
    .wstrb(wstrb_q), .wdata(wdata_q), .q(data_hi)
  );

  assign core_key  = {key_hi, key_lo};
  assign core_data = {data_hi, data_lo};

  logic start_fire, done_w1c;

  assign start_fire = wr_hit && (wr_off == REG_CTRL) && wstrb_q[0] && wdata_q[0] && !core_busy;
  assign done_w1c   = wr_hit && (wr_off == REG_STATUS) && wstrb_q[0] && wdata_q[STATUS_DONE_BIT];

  // A done strobe outranks any clear from START or W1C landing in the same cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      core_start <= 1'b0;
      done_q     <= 1'b0;
      res_lo     <= '0;
      res_hi     <= '0;
    end else begin
      core_start <= start_fire;
      if (core_done) begin
        done_q <= 1'b1;
        res_lo <= core_result[31:0];
        res_hi <= core_result[63:32];
      end else if (start_fire || done_w1c) begin
        done_q <= 1'b0;
      end
    end
  end

  logic          arready_q, rvalid_q;
  resp_t         rresp_q;
  logic [31:0]   rdata_q, rd_word;
  logic [AW-1:2] ar_word;

  assign ar_word = s_axi.S_AXI_ARADDR[AW-1:2];

  always_comb begin
    rd_word = '0;
    if (in_range(ar_word)) begin
      case (reg_off(ar_word))
        REG_STATUS: begin
          rd_word[STATUS_BUSY_BIT] = core_busy;
          rd_word[STATUS_DONE_BIT] = done_q;
        end
        REG_KEY_LO:  rd_word = key_lo;
        REG_KEY_HI:  rd_word = key_hi;
        REG_DATA_LO: rd_word = data_lo;
        REG_DATA_HI: rd_word = data_hi;
        REG_RES_LO:  rd_word = res_lo;
        REG_RES_HI:  rd_word = res_hi;
        default:     rd_word = '0;
      endcase
    end
  end

  // Read channel: data registered at the AR handshake, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      if (s_axi.S_AXI_ARVALID && arready_q) begin
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_word;
        rresp_q   <= in_range(ar_word) ? OKAY : SLVERR;
        arready_q <= 1'b0;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end else if (!rvalid_q) begin
        arready_q <= 1'b1;
      end
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_des_axil_slave_regs.sv
// Randomized self-checking bench for des_axil_slave_regs against a register-map
// model kept as plain arrays and flags.
module tb_des_axil_slave_regs;
  import des_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_start, core_busy, core_done;
  logic [63:0] core_key, core_data, core_result;

  always #5 clk = ~clk;

  des_axil_slave_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) axi ();

  des_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(clk), .ARESET(rst), .s_axi(axi),
    .core_start(core_start), .core_key(core_key), .core_data(core_data),
    .core_busy(core_busy), .core_done(core_done), .core_result(core_result)
  );

  int checks = 0;
  int errors = 0;
  int start_cycles = 0;

  always @(posedge clk) if (core_start) start_cycles <= start_cycles + 1;

  // Register-map model: word index -> value, plus the sticky DONE flag.
  logic [31:0] m_reg [8];
  logic        m_done;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_done = 1'b0;
  endtask

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic busy, output logic [1:0] resp, output int starts);
    int idx;
    logic [31:0] mask;
    starts = 0;
    resp = 2'b00;
    if (addr >= 6'h20) begin
      resp = 2'b10;
      return;
    end
    idx  = int'(addr) / 4;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (idx == 0) begin
      if (strb[0] && data[0] && !busy) begin
        starts = 1;
        m_done = 1'b0;
      end
    end else if (idx == 1) begin
      if (strb[0] && data[1]) m_done = 1'b0;
    end else if (idx <= 5) begin
      m_reg[idx] = (m_reg[idx] & ~mask) | (data & mask);
    end
  endtask

  task automatic model_done(input logic [63:0] res);
    m_reg[6] = res[31:0];
    m_reg[7] = res[63:32];
    m_done   = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] addr, input logic busy);
    int idx;
    if (addr >= 6'h20) return 32'h0;
    idx = int'(addr) / 4;
    if (idx == 0) return 32'h0;
    if (idx == 1) return {30'h0, m_done, busy};
    return m_reg[idx];
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input bit done_at_commit, input logic [63:0] res,
                           output logic [1:0] resp, output bit early_b, output bit b_unstable);
    int c;
    bit aw_d, w_d, hs_aw, hs_w;
    logic [1:0] r0;
    early_b = 0; b_unstable = 0; aw_d = 0; w_d = 0; c = 0; resp = 2'bxx;
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = strb;
    axi.S_AXI_BREADY = 1'b0;
    while (!(aw_d && w_d)) begin
      if (!aw_d && c >= aw_dly) axi.S_AXI_AWVALID = 1'b1;
      if (!w_d && c >= w_dly) axi.S_AXI_WVALID = 1'b1;
      hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      if (axi.S_AXI_BVALID) early_b = 1;
      @(posedge clk); #1;
      if (hs_aw) begin aw_d = 1; axi.S_AXI_AWVALID = 1'b0; end
      if (hs_w) begin w_d = 1; axi.S_AXI_WVALID = 1'b0; end
      c++;
      if (c > 200) begin
        checks++; errors++;
        $display("FAIL wr_handshake_timeout addr=%h: aw_done=%0d w_done=%0d, required both", addr, aw_d, w_d);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        return;
      end
    end
    if (done_at_commit) begin
      core_done = 1'b1;
      core_result = res;
    end
    c = 0;
    while (!axi.S_AXI_BVALID && c < 50) begin
      @(posedge clk); #1;
      core_done = 1'b0;
      c++;
    end
    core_done = 1'b0;
    if (!axi.S_AXI_BVALID) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr=%h: bvalid=0, required 1", addr);
      return;
    end
    r0 = axi.S_AXI_BRESP;
    repeat (b_dly) begin
      @(posedge clk); #1;
      if (!axi.S_AXI_BVALID || axi.S_AXI_BRESP !== r0) b_unstable = 1;
    end
    resp = axi.S_AXI_BRESP;
    axi.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit lat_ok);
    int c;
    c = 0; lat_ok = 0; data = 'x; resp = 2'bxx;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    while (!axi.S_AXI_ARREADY) begin
      @(posedge clk); #1;
      c++;
      if (c > 50) begin
        checks++; errors++;
        $display("FAIL arready_timeout addr=%h: arready=0, required 1", addr);
        axi.S_AXI_ARVALID = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    lat_ok = axi.S_AXI_RVALID;
    repeat (r_dly) begin @(posedge clk); #1; end
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          lat;
    rst = 1'b1;
    core_busy = 1'b0; core_done = 1'b0; core_result = '0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0;
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b0;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID,
         axi.S_AXI_RVALID, core_start} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: aw/w/ar_ready,b/r_valid,start=%b, required 000000",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY, axi.S_AXI_BVALID,
                axi.S_AXI_RVALID, core_start});
    end
    checks++;
    if ({core_key, core_data} !== 128'h0) begin
      errors++;
      $display("FAIL reset_regs: key=%h data=%h, required 0", core_key, core_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: aw/w/ar=%b, required 111",
               {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY});
    end
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b00 || !lat) begin
      errors++;
      $display("FAIL reset_status_read: data=%h resp=%b rvalid_next=%0d, required 00000000 00 1", d, r, lat);
    end
  endtask

  task automatic test_seq_rw();
    logic [31:0] d;
    logic [1:0]  r, er;
    bit          eb, bu, lat;
    int          st;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(8 + 4 * i), 32'(i + 1), 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
      model_write(6'(8 + 4 * i), 32'(i + 1), 4'hF, core_busy, er, st);
      checks++;
      if (r !== er) begin
        errors++;
        $display("FAIL seq_wr_resp[%0d]: resp=%b, required %b", i, r, er);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(8 + 4 * i), 1, d, r, lat);
      checks++;
      if (d !== 32'(i + 1) || d !== model_read(6'(8 + 4 * i), core_busy) || r !== 2'b00) begin
        errors++;
        $display("FAIL seq_rd[%0d]: data=%h resp=%b, required %h 00", i, d, r, i + 1);
      end
    end
    checks++;
    if (core_key !== 64'h0000000200000001 || core_data !== 64'h0000000400000003) begin
      errors++;
      $display("FAIL core_key_data: key=%h data=%h, required 0000000200000001 0000000400000003",
               core_key, core_data);
    end
  endtask

  task automatic test_strobe_order();
    logic [31:0] d;
    logic [1:0]  r, er;
    bit          eb, bu, lat;
    int          st;
    axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 3, 0, 5, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h08, 32'hAABBCCDD, 4'b0101, core_busy, er, st);
    checks++;
    if (eb || bu || r !== er) begin
      errors++;
      $display("FAIL strobe_bchan: early_b=%0d unstable=%0d resp=%b, required 0 0 %b", eb, bu, r, er);
    end
    axi_read(6'h08, 0, d, r, lat);
    checks++;
    if (d !== 32'h00BB00DD || d !== model_read(6'h08, core_busy)) begin
      errors++;
      $display("FAIL strobe_key_lo: data=%h, required 00BB00DD", d);
    end
  endtask

  task automatic test_start_done();
    logic [31:0] d;
    logic [1:0]  r, er;
    bit          eb, bu, lat;
    int          st, s0;
    core_busy = 1'b0;
    s0 = start_cycles;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h00, 32'h1, 4'hF, core_busy, er, st);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_cycles - s0 !== 1) begin
      errors++;
      $display("FAIL start_pulse: high_cycles=%0d, required 1", start_cycles - s0);
    end
    core_result = 64'h85E813540F0AB405;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    model_done(64'h85E813540F0AB405);
    axi_read(6'h18, 0, d, r, lat);
    checks++;
    if (d !== 32'h0F0AB405) begin
      errors++; $display("FAIL res_lo: data=%h, required 0F0AB405", d);
    end
    axi_read(6'h1C, 0, d, r, lat);
    checks++;
    if (d !== 32'h85E81354) begin
      errors++; $display("FAIL res_hi: data=%h, required 85E81354", d);
    end
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL status_done: data=%h, required 00000002", d);
    end
    axi_write(6'h04, 32'h2, 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h04, 32'h2, 4'hF, core_busy, er, st);
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL status_w1c: data=%h, required 00000000", d);
    end
    axi_write(6'h04, 32'h2, 4'hF, 1, 0, 0, 1'b1, 64'h1122334455667788, r, eb, bu);
    model_write(6'h04, 32'h2, 4'hF, core_busy, er, st);
    model_done(64'h1122334455667788);
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL w1c_vs_done: data=%h, required 00000002", d);
    end
    axi_write(6'h00, 32'h1, 4'h1, 0, 2, 0, 1'b1, 64'hDEADBEEF01234567, r, eb, bu);
    model_write(6'h00, 32'h1, 4'h1, core_busy, er, st);
    model_done(64'hDEADBEEF01234567);
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== 32'h2 || d !== model_read(6'h04, core_busy)) begin
      errors++; $display("FAIL start_vs_done: data=%h, required 00000002", d);
    end
    axi_read(6'h00, 0, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL ctrl_reads_zero: data=%h resp=%b, required 00000000 00", d, r);
    end
  endtask

  task automatic test_errors_busy();
    logic [31:0] d;
    logic [1:0]  r, er;
    bit          eb, bu, lat;
    int          st, s0;
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h20, 32'hFFFFFFFF, 4'hF, core_busy, er, st);
    checks++;
    if (r !== 2'b10 || r !== er) begin
      errors++; $display("FAIL oob_write_resp: resp=%b, required 10", r);
    end
    for (int i = 2; i < 8; i++) begin
      axi_read(6'(4 * i), 0, d, r, lat);
      checks++;
      if (d !== model_read(6'(4 * i), core_busy)) begin
        errors++;
        $display("FAIL oob_no_change[%0d]: data=%h, required %h", i, d, model_read(6'(4 * i), core_busy));
      end
    end
    axi_read(6'h3C, 0, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL oob_read: data=%h resp=%b, required 00000000 10", d, r);
    end
    core_busy = 1'b1;
    s0 = start_cycles;
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h00, 32'h1, 4'hF, core_busy, er, st);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (start_cycles - s0 !== 0 || r !== 2'b00) begin
      errors++;
      $display("FAIL start_while_busy: pulses=%0d resp=%b, required 0 00", start_cycles - s0, r);
    end
    axi_read(6'h04, 0, d, r, lat);
    checks++;
    if (d !== model_read(6'h04, core_busy)) begin
      errors++; $display("FAIL status_busy: data=%h, required %h", d, model_read(6'h04, core_busy));
    end
    core_busy = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] d, ed, data;
    logic [1:0]  r, er;
    logic [5:0]  addr;
    logic [3:0]  strb;
    logic [63:0] res;
    bit          eb, bu, lat, dac;
    int          st, s0;
    for (int n = 0; n < 60; n++) begin
      addr = 6'($urandom_range(0, 63));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      core_busy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        dac = ($urandom_range(0, 5) == 0);
        res = {$urandom, $urandom};
        s0 = start_cycles;
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  dac, res, r, eb, bu);
        model_write(addr, data, strb, core_busy, er, st);
        if (dac) model_done(res);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (r !== er || eb || bu || start_cycles - s0 !== st) begin
          errors++;
          $display("FAIL rand_wr[%0d] addr=%h: resp=%b early=%0d unstable=%0d start=%0d, required %b 0 0 %0d",
                   n, addr, r, eb, bu, start_cycles - s0, er, st);
        end
      end else begin
        ed = model_read(addr, core_busy);
        er = (addr >= 6'h20) ? 2'b10 : 2'b00;
        axi_read(addr, $urandom_range(0, 2), d, r, lat);
        checks++;
        if (d !== ed || r !== er || !lat) begin
          errors++;
          $display("FAIL rand_rd[%0d] addr=%h: data=%h resp=%b lat=%0d, required %h %b 1",
                   n, addr, d, r, lat, ed, er);
        end
      end
    end
    core_busy = 1'b0;
    checks++;
    if (core_key !== {m_reg[3], m_reg[2]} || core_data !== {m_reg[5], m_reg[4]}) begin
      errors++;
      $display("FAIL rand_core_outputs: key=%h data=%h, required %h %h",
               core_key, core_data, {m_reg[3], m_reg[2]}, {m_reg[5], m_reg[4]});
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    logic [1:0]  r, er;
    bit          eb, bu, lat;
    int          st, c;
    axi_write(6'h10, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, 64'h0, r, eb, bu);
    model_write(6'h10, 32'h12345678, 4'hF, core_busy, er, st);
    axi.S_AXI_AWADDR = 6'h14; axi.S_AXI_WDATA = 32'hCAFEF00D; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_BREADY = 1'b0;
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_b: aw/w=%b, required 11", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY});
    end
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    c = 0;
    while (!axi.S_AXI_BVALID && c < 20) begin @(posedge clk); #1; c++; end
    checks++;
    if (!axi.S_AXI_BVALID) begin
      errors++; $display("FAIL midop_bvalid: bvalid=0, required 1");
    end
    rst = 1'b1;
    #1;
    checks++;
    if (axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_AWREADY !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: bvalid=%b awready=%b, required 0 0", axi.S_AXI_BVALID, axi.S_AXI_AWREADY);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 2; i < 6; i++) begin
      axi_read(6'(4 * i), 0, d, r, lat);
      checks++;
      if (d !== 32'h0 || d !== model_read(6'(4 * i), core_busy)) begin
        errors++; $display("FAIL midop_reg_clear[%0d]: data=%h, required 00000000", i, d);
      end
    end
    checks++;
    if (axi.S_AXI_BVALID !== 1'b0) begin
      errors++; $display("FAIL midop_no_stale_b: bvalid=%b, required 0", axi.S_AXI_BVALID);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seq_rw();
    test_strobe_order();
    test_start_done();
    test_errors_busy();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_axil_slave_regs.md
Name: des_axil_slave_regs

Overview:
- AXI4-Lite slave (responder) register front end for the DES pipeline core; the target of the bench's AXI VIP master.
- Decodes single-beat writes and reads into a 32-bit register bank: control, status, key, data in, result.
- Drives a start pulse plus key/data to the DES core and captures the core's 64-bit result on its done strobe.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width; the decoded window is 0x00-0x1C.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- core_start  out  1  one-cycle start pulse to the DES core.
- core_key  out  64  {KEY_HI, KEY_LO}.
- core_data  out  64  {DATA_HI, DATA_LO}.
- core_busy  in  1  core is processing.
- core_done  in  1  one-cycle pulse; core_result is valid in the same cycle.
- core_result  in  64  ciphertext/plaintext result.

Behaviour:
- Reset: all ready, valid and response outputs are 0; all registers are 0; core_start is 0. AWREADY, WREADY and ARREADY rise in the first cycle after ARESET deasserts.
- Register map (addr[4:2]):
  - 0x00 CTRL (W): bit0 START, self-clearing; reads 0.
  - 0x04 STATUS (R / W1C): bit0 BUSY = core_busy; bit1 DONE, sticky.
  - 0x08 KEY_LO, 0x0C KEY_HI, 0x10 DATA_LO, 0x14 DATA_HI: RW, honour WSTRB per byte.
  - 0x18 RES_LO, 0x1C RES_HI: RO; writes are ignored but return OKAY.
- Address decode: any address with a bit set above bit 4 is out of range. Out-of-range writes are dropped with BRESP = SLVERR (2'b10). Out-of-range reads return RDATA = 0 with RRESP = SLVERR. In-range responses are OKAY (2'b00). addr[1:0] is ignored.
- Write channel:
  - AW and W are accepted independently; each ready drops for the cycle after its handshake and stays low while that beat is held.
  - Register update happens in the cycle both beats are held. BVALID asserts the next cycle.
  - AWREADY and WREADY stay low until the B handshake (BVALID & BREADY). BVALID holds and BRESP stays stable until then.
  - Only one write is outstanding.
- Read channel:
  - ARREADY is high whenever RVALID is low.
  - On the AR handshake, RDATA/RRESP are registered; RVALID asserts the next cycle (1-cycle latency).
  - RVALID, RDATA and RRESP hold stable until RREADY; ARREADY is low while RVALID is high.
- Read and write are independent. If a read samples a register in the same cycle a write commits to it, the read returns the old value.
- START: writing CTRL with WSTRB[0] = 1 and WDATA[0] = 1 pulses core_start for exactly one cycle, 1 cycle after the commit cycle. The write is ignored if core_busy = 1 (response still OKAY). START also clears DONE.
- Done: on core_done, RES_LO/HI are captured from core_result and DONE is set. If core_done coincides with a STATUS W1C of bit1, the set wins. If core_done coincides with a START, DONE ends set.
- ARESET mid-transaction: all in-flight AW/W/AR/B/R state is abandoned immediately; no response is issued for it.

Decomposition:
- Package des_axil_pkg holds:
  - register offset localparams: REG_CTRL … REG_RES_HI;
  - the resp_t enum: OKAY = 2'b00, SLVERR = 2'b10;
  - STATUS bit index constants.
- Sub-module des_axil_wstrb_reg: one 32-bit register with byte-enable write, instantiated 4 times for KEY/DATA. Decode and handshake logic stays in the top module.

Test Plan:
- Reset and ID: ARESET high for 10 cycles, then read 0x04 with core_busy = 0 -> RDATA = 0x00000000, RRESP = OKAY, RVALID 1 cycle after the AR handshake.
- Sequential RW: write 0x00000001..0x00000004 to 0x08/0x0C/0x10/0x14 with WSTRB = 0xF, then read back -> exact match; core_key = 0x0000000200000001, core_data = 0x0000000400000003.
- Strobe and ordering: W beat 3 cycles before AW; write 0xAABBCCDD with WSTRB = 0b0101 to 0x08 (holding 0x00000001) -> KEY_LO = 0x00BB00DD; BVALID only after both beats; BREADY held low 5 cycles -> BVALID and BRESP stable.
- Start/done: write CTRL = 1 -> core_start high exactly one cycle. Then core_done with core_result = 0x85E813540F0AB405 -> RES_LO reads 0x0F0AB405, RES_HI reads 0x85E81354, STATUS = 0x2. Write STATUS = 0x2 -> STATUS = 0x0. core_done in the same cycle as the W1C -> STATUS = 0x2.
- Errors and busy: write 0x20 -> BRESP = SLVERR and no register changes. Read 0x3C -> RDATA = 0, RRESP = SLVERR. CTRL = 1 while core_busy = 1 -> no core_start.
- Reset mid-op: assert ARESET while BVALID = 1 and BREADY = 0 -> BVALID = 0 immediately, KEY/DATA read 0 after release.
